// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register file defaults, popcount width and address type.
package cpu_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 4;
  localparam int NUM_RD_DEF   = 2;

  // Width needed to count 0..NUM_REGS_DEF pending registers.
  localparam int PCNT_W_DEF   = $clog2(NUM_REGS_DEF + 1);

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bits, reservation/clear, conflict flag and busy count.
// Honours REGFILE_ZERO_REG_EN (register 0 can never be reserved).
module regfile_scoreboard #(
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_conflict,
  output logic [CNT_W-1:0]    pend_cnt
);

  logic                rsv_take;
  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_W-1:0]    cnt_next;

`ifdef REGFILE_ZERO_REG_EN
  assign rsv_take = rsv_en && (rsv_addr != '0);
`else
  assign rsv_take = rsv_en;
`endif

  assign rsv_conflict = rsv_take && busy[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));

  // Reservation is applied after the clear so a same-edge write+reserve leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[wr_addr] = 1'b0;
    if (rsv_take)
      busy_next[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_next;
      pend_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-port write-through bypass and pending-write scoreboard.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_RD*AW-1:0]            rd_addr,
  output logic [NUM_RD*DATA_W-1:0]        rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            rsv_en,
  input  logic [AW-1:0]                   rsv_addr,
  output logic                            rsv_conflict,
  output logic [$clog2(NUM_REGS+1)-1:0]   pend_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_take;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_take = wr_en && (wr_addr != '0);
`else
  assign wr_take = wr_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_take) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .CNT_W    ($clog2(NUM_REGS+1))
  ) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .busy         (busy),
    .rsv_conflict (rsv_conflict),
    .pend_cnt     (pend_cnt)
  );

  // Each port bypasses independently; a landing write also hides that register's busy bit.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[p*AW +: AW];
    assign hit  = wr_en && (wr_addr == addr);

`ifdef REGFILE_ZERO_REG_EN
    assign rd_data[p*DATA_W +: DATA_W] = (addr == '0) ? '0 : (hit ? wr_data : regs[addr]);
`else
    assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : regs[addr];
`endif

    assign rd_busy[p] = busy[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default 16x4x2 instance plus a 32x8x3 instance.
// Follows REGFILE_ZERO_REG_EN when the build defines it.
module tb_regfile_sb;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  d0_rd_addr;
  logic [31:0] d0_rd_data;
  logic [1:0]  d0_rd_busy;
  logic        d0_wr_en, d0_rsv_en, d0_conf;
  logic [1:0]  d0_wr_addr, d0_rsv_addr;
  logic [15:0] d0_wr_data;
  logic [2:0]  d0_cnt;

  logic [8:0]  d1_rd_addr;
  logic [95:0] d1_rd_data;
  logic [2:0]  d1_rd_busy;
  logic        d1_wr_en, d1_rsv_en, d1_conf;
  logic [2:0]  d1_wr_addr, d1_rsv_addr;
  logic [31:0] d1_wr_data;
  logic [3:0]  d1_cnt;

  regfile_sb dut0 (
    .clk(clk), .reset_n(reset_n), .rd_addr(d0_rd_addr), .rd_data(d0_rd_data),
    .rd_busy(d0_rd_busy), .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
    .rsv_en(d0_rsv_en), .rsv_addr(d0_rsv_addr), .rsv_conflict(d0_conf), .pend_cnt(d0_cnt)
  );

  regfile_sb #(.DATA_W(32), .NUM_REGS(8), .NUM_RD(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data),
    .rd_busy(d1_rd_busy), .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
    .rsv_en(d1_rsv_en), .rsv_addr(d1_rsv_addr), .rsv_conflict(d1_conf), .pend_cnt(d1_cnt)
  );

  typedef struct packed {
    logic            sel;
    logic [2:0][31:0] d;
    logic [2:0]      busy;
    logic            conf;
    logic [3:0]      cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mregs [2][8];
  bit          mbusy [2][8];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++) begin
        mregs[s][r] = '0;
        mbusy[s][r] = 1'b0;
      end
  endtask

  task automatic compareCycle();
    exp_t e;
    logic [2:0][31:0] od;
    logic [2:0] ob;
    logic oc;
    logic [3:0] on;
    int nrd;
    checkOutput($sformatf("c%0d sb_depth", cyc), sbq.size(), 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    nrd = e.sel ? 3 : 2;
    if (e.sel) begin
      for (int i = 0; i < 3; i++) od[i] = d1_rd_data[i*32 +: 32];
      ob = d1_rd_busy; oc = d1_conf; on = d1_cnt;
    end else begin
      od[2] = '0;
      for (int i = 0; i < 2; i++) od[i] = d0_rd_data[i*16 +: 16];
      ob = {1'b0, d0_rd_busy}; oc = d0_conf; on = {1'b0, d0_cnt};
    end
    for (int i = 0; i < nrd; i++) begin
      checkOutput($sformatf("c%0d dut%0d rd_data%0d", cyc, e.sel, i), od[i], e.d[i]);
      checkOutput($sformatf("c%0d dut%0d rd_busy%0d", cyc, e.sel, i), 32'(ob[i]), 32'(e.busy[i]));
    end
    checkOutput($sformatf("c%0d dut%0d rsv_conflict", cyc, e.sel), 32'(oc), 32'(e.conf));
    checkOutput($sformatf("c%0d dut%0d pend_cnt", cyc, e.sel), 32'(on), 32'(e.cnt));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input int sel, input bit we, input int wa, input logic [31:0] wd,
                               input bit re, input int ra, input int a0, input int a1, input int a2);
    exp_t e;
    int a [3];
    logic [31:0] wdm;
    int nrd;
    a[0] = a0; a[1] = a1; a[2] = a2;
    nrd = sel ? 3 : 2;
    wdm = sel ? wd : {16'h0, wd[15:0]};
    d0_wr_en = 1'b0; d0_rsv_en = 1'b0; d1_wr_en = 1'b0; d1_rsv_en = 1'b0;
    if (sel == 0) begin
      d0_wr_en = we; d0_wr_addr = 2'(wa); d0_wr_data = wd[15:0];
      d0_rsv_en = re; d0_rsv_addr = 2'(ra);
      d0_rd_addr = {2'(a1), 2'(a0)};
    end else begin
      d1_wr_en = we; d1_wr_addr = 3'(wa); d1_wr_data = wd;
      d1_rsv_en = re; d1_rsv_addr = 3'(ra);
      d1_rd_addr = {3'(a2), 3'(a1), 3'(a0)};
    end
    #1;
    e = '0;
    e.sel = (sel != 0);
    for (int i = 0; i < nrd; i++) begin
      if (ZR && a[i] == 0)             e.d[i] = '0;
      else if (we && wa == a[i])       e.d[i] = wdm;
      else                             e.d[i] = mregs[sel][a[i]];
      e.busy[i] = mbusy[sel][a[i]] && !(we && wa == a[i]);
    end
    e.conf = re && !(ZR && ra == 0) && mbusy[sel][ra] && !(we && wa == ra);
    for (int r = 0; r < (sel ? 8 : 4); r++) e.cnt = e.cnt + 4'(mbusy[sel][r]);
    sbq.push_back(e);
    #1;
    compareCycle();
    @(posedge clk);
    if (we && !(ZR && wa == 0)) mregs[sel][wa] = wdm;
    if (we) mbusy[sel][wa] = 1'b0;
    if (re && !(ZR && ra == 0)) mbusy[sel][ra] = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    d0_wr_en = 0; d0_rsv_en = 0; d0_wr_addr = 0; d0_rsv_addr = 0; d0_wr_data = 0; d0_rd_addr = 0;
    d1_wr_en = 0; d1_rsv_en = 0; d1_wr_addr = 0; d1_rsv_addr = 0; d1_wr_data = 0; d1_rd_addr = 0;
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state, then a write that a mid-cycle reset must wipe.
    applyStimulus(0, 0, 0, 0,          0, 0, 0, 1, 0);
    applyStimulus(0, 1, 2, 32'hBEEF,   1, 1, 2, 2, 0);
    applyStimulus(0, 0, 0, 0,          1, 3, 2, 1, 0);
    d0_rd_addr = {2'd1, 2'd2};
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst rd_data0", d0_rd_data[15:0], 32'h0);
    checkOutput("async_rst rd_data1", d0_rd_data[31:16], 32'h0);
    checkOutput("async_rst rd_busy", 32'(d0_rd_busy), 32'h0);
    checkOutput("async_rst pend_cnt", 32'(d0_cnt), 32'h0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0,          0, 0, 2, 2, 0);

    // Dual bypass.
    applyStimulus(0, 1, 3, 32'h1234,   0, 0, 3, 3, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 3, 3, 0);

    // Reserve, then clear with a bypassed write.
    applyStimulus(0, 0, 0, 0,          1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'h00AA,   0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 1, 1, 0);

    // Same-edge write+reserve, then a conflicting second reservation.
    applyStimulus(0, 1, 2, 32'h5555,   1, 2, 2, 0, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 2, 2, 0);
    applyStimulus(0, 0, 0, 0,          1, 2, 2, 2, 0);
    applyStimulus(0, 1, 2, 32'h6666,   1, 2, 2, 3, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 2, 3, 0);

    // Register 0: ordinary or hardwired zero depending on the build.
    applyStimulus(0, 1, 0, 32'hFFFF,   1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0,          1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0,          0, 0, 0, 2, 0);

    for (int k = 0; k < 40; k++)
      applyStimulus(0, $urandom_range(1), $urandom_range(3), $urandom, $urandom_range(1),
                    $urandom_range(3), $urandom_range(3), $urandom_range(3), 0);

    // Wide instance: reserve everything, then write r7 through all three ports.
    for (int r = 0; r < 8; r++)
      applyStimulus(1, 0, 0, 0, 1, r, r, 0, 7);
    applyStimulus(1, 0, 0, 0,            0, 0, 0, 3, 7);
    applyStimulus(1, 1, 7, 32'hDEADBEEF, 0, 0, 7, 7, 7);
    applyStimulus(1, 0, 0, 0,            0, 0, 7, 6, 5);

    for (int k = 0; k < 40; k++)
      applyStimulus(1, $urandom_range(1), $urandom_range(7), $urandom, $urandom_range(1),
                    $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file with write-through bypass and a per-register pending-write scoreboard.
- Sits in the CPU datapath at the ID stage. Read ports feed the operand latches.
- The hazard unit uses the busy outputs to stall on registers that an in-flight multi-cycle op has reserved but not yet written.
- Next generation of the 4x16 two-port file: generalised width, depth and read-port count, with bypass applied independently per port.

Parameters:
- DATA_W, 16: register width in bits.
- NUM_REGS, 4: number of registers; power of 2, at least 2.
- NUM_RD, 2: number of combinational read ports, at least 1.
- AW, $clog2(NUM_REGS): address width (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-port: the addressed register has a pending write.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve a destination (set its busy bit).
- rsv_addr  in  AW  register to reserve.
- rsv_conflict  out  1  rsv_en targets an already-busy register that is not being written this cycle.
- pend_cnt  out  $clog2(NUM_REGS+1)  number of busy bits currently set.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset asserted: all registers = 0; all busy bits = 0; pend_cnt = 0. Reset takes effect immediately, without a clock edge.
- Reset deasserted mid-operation: no partial state survives. The first clock edge after deassertion behaves as a normal cycle.
- Write: at posedge clk, if wr_en, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - A write to a non-busy register is legal; it is a plain write.
- Reservation: at posedge clk, if rsv_en, busy[rsv_addr] <= 1.
  - Same edge, wr_en and rsv_en to the same address: data is written AND busy ends at 1. Reservation wins, because a new writer is in flight.
- Read: combinational, zero latency. Each port is evaluated independently; there is no priority between ports.
  - rd_data[i] = (wr_en && wr_addr == rd_addr[i]) ? wr_data : regs[rd_addr[i]].
  - All ports reading the register being written see wr_data in the same cycle.
- rd_busy[i] = busy[rd_addr[i]] && !(wr_en && wr_addr == rd_addr[i]).
  - A write landing this cycle clears visible busy, so the consumer need not stall.
  - rsv_en in the current cycle does not affect rd_busy until the next cycle.
- rsv_conflict (combinational) = rsv_en && busy[rsv_addr] && !(wr_en && wr_addr == rsv_addr).
  - Informational only: the reservation is still taken and busy stays 1.
- pend_cnt: registered population count of the busy vector, updated at the same edge as busy. It never exceeds NUM_REGS.
- Addresses are always in range, since NUM_REGS is a power of 2.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to it are dropped.
  - Reads of address 0 return 0 and are never bypassed.
  - Reservations of address 0 are ignored: busy[0] stays 0 and rsv_conflict is never asserted for address 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package cpu_pkg holds:
  - regfile defaults (DATA_W_DEF = 16, NUM_REGS_DEF = 4, NUM_RD_DEF = 2);
  - a popcount width helper constant;
  - typedef reg_addr_t.
- One natural sub-module: regfile_scoreboard, which owns the busy vector, reservation/clear logic, rsv_conflict and pend_cnt. The top holds the storage array and the per-port bypass muxes via a generate loop.

Test Plan:
- Reset: assert reset_n = 0 asynchronously mid-cycle after writing 0xBEEF to r2 -> all rd_data = 0, rd_busy = 0, pend_cnt = 0 immediately; then a read of r2 returns 0.
- Dual bypass: wr_en = 1, wr_addr = 3, wr_data = 0x1234, rd_addr = {3,3} -> both ports show 0x1234 in the same cycle; both still read 0x1234 the cycle after with wr_en = 0.
- Scoreboard: rsv r1 -> next cycle rd_busy = 1 for a port on r1 and pend_cnt = 1. Write r1 = 0x00AA -> rd_busy = 0 in that cycle with rd_data = 0x00AA; pend_cnt = 0 after the edge.
- Simultaneous events: same cycle wr r2 = 0x5555 and rsv r2 -> after the edge regs[2] = 0x5555, busy[2] = 1, pend_cnt = 1. A second rsv of r2 (no write) -> rsv_conflict = 1, busy[2] still 1.
- Parametrisation: DATA_W = 32, NUM_REGS = 8, NUM_RD = 3; reserve all 8 registers -> pend_cnt = 8. Write r7 = 0xDEADBEEF with all three ports reading r7 -> all three show 0xDEADBEEF; pend_cnt = 7.
- With REGFILE_ZERO_REG_EN: write r0 = 0xFFFF and rsv r0 -> read r0 = 0, rd_busy = 0, rsv_conflict = 0, pend_cnt unchanged.
